// File: rtl/axi_lite_line_xfer_ctrl.sv
// rtl/axi_lite_line_xfer_ctrl.sv - cache-line refill/writeback sequencer over AXI4-Lite
//
// Purpose:
//    Runs one cache line as BEATS single-beat AXI4-Lite transactions, either reads
//    (refill) or writes (writeback). The module owns the beat counter and all channel
//    handshakes, and keeps at most one transaction outstanding.
//
// Optional feature macro: AXI_ERR_ABORT_EN
//    When defined, the first error response ends the line early and goes to DONE.
//    When undefined, an error is only recorded in o_err and every beat still runs.
//
// Ports:
//    clk, arst                      clock (rising edge), asynchronous active-high reset
//    i_start_rd / i_start_wr        start refill / writeback (sampled in IDLE, write wins)
//    i_base_addr                    line base address, captured at start
//    i_wdata                        write data for beat o_beat_idx, supplied by requester
//    o_beat_idx                     current beat index
//    o_rdata, o_rdata_vld           read data of the last accepted R beat, 1-cycle strobe
//    o_busy, o_done, o_err          not-IDLE, end-of-line pulse, sticky error response
//    m_ar*, m_r*, m_aw*, m_w*, m_b* AXI4-Lite master channels
module axi_lite_line_xfer_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = 16
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       i_start_rd,
   input  logic                       i_start_wr,
   input  logic [ADDR_W-1:0]          i_base_addr,
   input  logic [DATA_W-1:0]          i_wdata,
   output logic [$clog2(BEATS)-1:0]   o_beat_idx,
   output logic [DATA_W-1:0]          o_rdata,
   output logic                       o_rdata_vld,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err,
   output logic [ADDR_W-1:0]          m_araddr,
   output logic                       m_arvalid,
   input  logic                       m_arready,
   input  logic [DATA_W-1:0]          m_rdata,
   input  logic [1:0]                 m_rresp,
   input  logic                       m_rvalid,
   output logic                       m_rready,
   output logic [ADDR_W-1:0]          m_awaddr,
   output logic                       m_awvalid,
   input  logic                       m_awready,
   output logic [DATA_W-1:0]          m_wdata,
   output logic [DATA_W/8-1:0]        m_wstrb,
   output logic                       m_wvalid,
   input  logic                       m_wready,
   input  logic [1:0]                 m_bresp,
   input  logic                       m_bvalid,
   output logic                       m_bready
);

   localparam int CNT_W  = $clog2(BEATS);
   localparam int STRB_W = DATA_W / 8;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

`ifdef AXI_ERR_ABORT_EN
   localparam logic ABORT_EN = 1'b1;
`else
   localparam logic ABORT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      RD_AR,
      RD_R,
      WR_AWW,
      WR_B,
      DONE
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [ADDR_W-1:0]   base, base_nxt;
   logic                aw_ok, aw_ok_nxt;
   logic                w_ok, w_ok_nxt;
   logic                err, err_nxt;
   logic [DATA_W-1:0]   rdata_q, rdata_nxt;
   logic                rvld_q, rvld_nxt;
   logic [ADDR_W-1:0]   beat_addr;
   logic                aw_done, w_done;
   logic                resp_err, line_end;

   // Address arithmetic is ADDR_W wide so a line crossing the top of the map wraps.
   assign beat_addr = base + (ADDR_W'(cnt) * ADDR_W'(STRB_W));

   assign m_araddr    = beat_addr;
   assign m_awaddr    = beat_addr;
   assign m_wdata     = i_wdata;
   assign m_wstrb     = '1;
   assign o_beat_idx  = cnt;
   assign o_rdata     = rdata_q;
   assign o_rdata_vld = rvld_q;
   assign o_err       = err;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state   <= IDLE;
         cnt     <= '0;
         base    <= '0;
         aw_ok   <= 1'b0;
         w_ok    <= 1'b0;
         err     <= 1'b0;
         rdata_q <= '0;
         rvld_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         base    <= base_nxt;
         aw_ok   <= aw_ok_nxt;
         w_ok    <= w_ok_nxt;
         err     <= err_nxt;
         rdata_q <= rdata_nxt;
         rvld_q  <= rvld_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      base_nxt  = base;
      aw_ok_nxt = aw_ok;
      w_ok_nxt  = w_ok;
      err_nxt   = err;
      rdata_nxt = rdata_q;
      rvld_nxt  = 1'b0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      o_busy    = (state != IDLE);
      o_done    = 1'b0;
      aw_done   = 1'b0;
      w_done    = 1'b0;
      resp_err  = 1'b0;
      line_end  = 1'b0;

      case (state)
         IDLE: begin
            // Writeback wins so a dirty victim leaves before the refill overwrites it.
            if (i_start_wr || i_start_rd) begin
               base_nxt  = i_base_addr;
               cnt_nxt   = '0;
               err_nxt   = 1'b0;
               aw_ok_nxt = 1'b0;
               w_ok_nxt  = 1'b0;
               state_nxt = i_start_wr ? WR_AWW : RD_AR;
            end
         end

         RD_AR: begin
            m_arvalid = 1'b1;
            if (m_arready) begin
               state_nxt = RD_R;
            end
         end

         RD_R: begin
            m_rready = 1'b1;
            if (m_rvalid) begin
               rdata_nxt = m_rdata;
               rvld_nxt  = 1'b1;
               resp_err  = (m_rresp != 2'b00);
               if (resp_err) begin
                  err_nxt = 1'b1;
               end
               line_end = (cnt == LAST_IDX) || (ABORT_EN && resp_err);
               if (line_end) begin
                  state_nxt = DONE;
               end else begin
                  cnt_nxt   = cnt + CNT_W'(1);
                  state_nxt = RD_AR;
               end
            end
         end

         WR_AWW: begin
            // AW and W complete independently; a flag remembers each finished half so
            // its valid drops while the other channel is still waiting.
            m_awvalid = !aw_ok;
            m_wvalid  = !w_ok;
            aw_done   = aw_ok || m_awready;
            w_done    = w_ok || m_wready;
            aw_ok_nxt = aw_done;
            w_ok_nxt  = w_done;
            if (aw_done && w_done) begin
               aw_ok_nxt = 1'b0;
               w_ok_nxt  = 1'b0;
               state_nxt = WR_B;
            end
         end

         WR_B: begin
            m_bready = 1'b1;
            if (m_bvalid) begin
               resp_err = (m_bresp != 2'b00);
               if (resp_err) begin
                  err_nxt = 1'b1;
               end
               line_end = (cnt == LAST_IDX) || (ABORT_EN && resp_err);
               if (line_end) begin
                  state_nxt = DONE;
               end else begin
                  cnt_nxt   = cnt + CNT_W'(1);
                  state_nxt = WR_AWW;
               end
            end
         end

         DONE: begin
            o_done    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
